// File: rtl/axi_adder_pkg.sv
// Shared constants and helpers for the AXI4-Lite adder slave.
// Register offsets are word indices taken from address bits [3:2].
package axi_adder_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 16;

  localparam logic [1:0] ADDR_A      = 2'd0;
  localparam logic [1:0] ADDR_B      = 2'd1;
  localparam logic [1:0] ADDR_SUM    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] reg_sel_t;

  function automatic logic [DATA_W-1:0] merge_strb(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_adder_core.sv
// Registered 32-bit adder with carry, busy flag and wrapping update counter.
// A start request defers the update by one edge so the latest operands are used.
module axi_adder_core
  import axi_adder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              start_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W:0]   add_full;

  assign add_full = {1'b0, a_i} + {1'b0, b_i};

  // A new start always wins so exactly one update follows the last operand write.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    count_d = count_q;
    if (start_i) begin
      busy_d = 1'b1;
    end else if (busy_q) begin
      sum_d   = add_full[DATA_W-1:0];
      carry_d = add_full[DATA_W];
      count_d = count_q + 16'd1;
      busy_d  = 1'b0;
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/axi_adder_slave.sv
// AXI4-Lite slave exposing operands A/B, the registered sum and a status word.
// AW and W are latched independently; the write commits once both are present.
module axi_adder_slave
  import axi_adder_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  logic              aw_pending_q, aw_pending_d;
  reg_sel_t          awsel_q, awsel_d;
  logic              w_pending_q, w_pending_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic              aw_ready, w_ready, ar_ready;
  logic              aw_hs, w_hs, ar_hs;
  logic              commit;
  reg_sel_t          wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              start;
  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] status_word;
  logic              unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are held low while reset is asserted and otherwise follow the flags.
  assign aw_ready = !S_AXI_ARESET && !aw_pending_q && !bvalid_q;
  assign w_ready  = !S_AXI_ARESET && !w_pending_q && !bvalid_q;
  assign ar_ready = !S_AXI_ARESET && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && aw_ready;
  assign w_hs  = S_AXI_WVALID && w_ready;
  assign ar_hs = S_AXI_ARVALID && ar_ready;

  assign commit  = (aw_pending_q || aw_hs) && (w_pending_q || w_hs);
  assign wr_sel  = aw_pending_q ? awsel_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_pending_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_pending_q ? wstrb_q : S_AXI_WSTRB;
  assign start   = commit && ((wr_sel == ADDR_A) || (wr_sel == ADDR_B));

  assign status_word = {count, 14'd0, busy, carry};

  // Write channel: latch AW/W, commit into the register file, hold B until accepted.
  always_comb begin
    aw_pending_d = aw_pending_q;
    awsel_d      = awsel_q;
    w_pending_d  = w_pending_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    a_d          = a_q;
    b_d          = b_q;
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_pending_d = 1'b0;
      w_pending_d  = 1'b0;
      bvalid_d     = 1'b1;
      case (wr_sel)
        ADDR_A: begin
          a_d     = merge_strb(a_q, wr_data, wr_strb);
          bresp_d = RESP_OKAY;
        end
        ADDR_B: begin
          b_d     = merge_strb(b_q, wr_data, wr_strb);
          bresp_d = RESP_OKAY;
        end
        default: bresp_d = RESP_SLVERR;
      endcase
    end else begin
      if (aw_hs) begin
        aw_pending_d = 1'b1;
        awsel_d      = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_pending_d = 1'b1;
        wdata_d     = S_AXI_WDATA;
        wstrb_d     = S_AXI_WSTRB;
      end
    end
  end

  // Read channel: capture register values as they stand before this edge.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (S_AXI_ARADDR[3:2])
        ADDR_A:   rdata_d = a_q;
        ADDR_B:   rdata_d = b_q;
        ADDR_SUM: rdata_d = sum;
        default:  rdata_d = status_word;
      endcase
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_pending_q <= 1'b0;
      awsel_q      <= '0;
      w_pending_q  <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      aw_pending_q <= aw_pending_d;
      awsel_q      <= awsel_d;
      w_pending_q  <= w_pending_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  axi_adder_core u_core (
    .clk_i   (S_AXI_ACLK),
    .rst_i   (S_AXI_ARESET),
    .a_i     (a_q),
    .b_i     (b_q),
    .start_i (start),
    .sum_o   (sum),
    .carry_o (carry),
    .busy_o  (busy),
    .count_o (count)
  );

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_adder_slave.sv
// Scoreboard bench for axi_adder_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares on every B/R handshake.
module tb_axi_adder_slave;

  logic        clk;
  logic        rst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  logic [1:0]  wq[$];
  logic [33:0] rq[$];

  axi_adder_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response handshake happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    if (!rst && bvalid && bready) begin
      if (wq.size() == 0) begin
        check("unexpected_bvalid", {31'd0, bvalid}, 32'd0);
      end else begin
        check("bresp", {30'd0, bresp}, {30'd0, wq.pop_front()});
      end
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        check("unexpected_rvalid", {31'd0, rvalid}, 32'd0);
      end else begin
        logic [33:0] e;
        e = rq.pop_front();
        check("rdata", rdata, e[31:0]);
        check("rresp", {30'd0, rresp}, {30'd0, e[33:32]});
      end
    end
  end

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input logic [1:0] exp_resp);
    bit aw_done, w_done, aw_now, w_now;
    int cyc;
    wq.push_back(exp_resp);
    awaddr = addr; wdata = data; wstrb = strb;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      wvalid  = !w_done;
      awvalid = !aw_done && (cyc >= lead);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done || aw_now;
      w_done  = w_done || w_now;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) check("write_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
    int cyc;
    rq.push_back({2'b00, exp});
    araddr = addr; arvalid = 1'b1; cyc = 0;
    while (!arready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 50) check("read_timeout", 32'd1, 32'd0);
    else begin
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while ((wq.size() != 0 || rq.size() != 0 || bvalid || rvalid) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 60) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; awaddr = 4'h0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'h0;
    wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1; araddr = 4'h0; arprot = 3'd0;
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_awready", {31'd0, awready}, 32'd1);
    check("post_rst_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;

    // Basic add with AW and W together.
    do_write(4'h0, 32'h0000_0001, 4'hF, 0, 2'b00);
    check("bvalid_same_cycle", {31'd0, bvalid}, 32'd1);
    wait_idle();
    do_write(4'h4, 32'h0000_0002, 4'hF, 0, 2'b00);
    wait_idle();
    do_read(4'h8, 32'h0000_0003);
    do_read(4'hC, 32'h0002_0000);
    do_read(4'h0, 32'h0000_0001);
    do_read(4'h4, 32'h0000_0002);
    wait_idle();

    // Carry case, W leading AW by three cycles.
    do_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
    wait_idle();
    do_write(4'h4, 32'h0000_0001, 4'hF, 3, 2'b00);
    check("bvalid_after_aw", {31'd0, bvalid}, 32'd1);
    wait_idle();
    do_read(4'h8, 32'h0000_0000);
    do_read(4'hC, 32'h0004_0001);
    wait_idle();

    // Byte strobe merge.
    do_write(4'h0, 32'h1122_3344, 4'hF, 0, 2'b00);
    wait_idle();
    do_write(4'h0, 32'hAABB_CCDD, 4'b0101, 1, 2'b00);
    wait_idle();
    do_read(4'h0, 32'h11BB_33DD);
    wait_idle();

    // Read-only targets answer SLVERR; zero strobe still updates.
    do_write(4'h8, 32'h1234_5678, 4'hF, 0, 2'b10);
    wait_idle();
    do_write(4'hC, 32'h8765_4321, 4'hF, 2, 2'b10);
    wait_idle();
    do_write(4'h7, 32'hDEAD_BEEF, 4'h0, 0, 2'b00);
    wait_idle();
    do_read(4'hA, 32'h11BB_33DE);
    do_read(4'h4, 32'h0000_0001);
    do_read(4'hF, 32'h0007_0000);
    wait_idle();

    // Backpressure on both response channels.
    bready = 1'b0; rready = 1'b0;
    do_write(4'h0, 32'h0000_0005, 4'hF, 0, 2'b00);
    do_read(4'h4, 32'h0000_0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_bvalid", {31'd0, bvalid}, 32'd1);
      check("stall_bresp", {30'd0, bresp}, 32'd0);
      check("stall_rvalid", {31'd0, rvalid}, 32'd1);
      check("stall_rdata", rdata, 32'h0000_0001);
      check("stall_ready", {29'd0, awready, wready, arready}, 32'd0);
    end
    bready = 1'b1; rready = 1'b1;
    wait_idle();

    // Reset with an address latched but no data.
    awaddr = 4'h0; wdata = 32'h0000_0099; wstrb = 4'hF; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_pending_blocks", {31'd0, awready}, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_bvalid_after_rst", {31'd0, bvalid}, 32'd0);
    end
    check("awready_after_rst", {31'd0, awready}, 32'd1);
    do_read(4'h0, 32'h0000_0000);
    do_read(4'hC, 32'h0000_0000);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_adder_slave.md
# axi_adder_slave

AXI4-Lite responder that exposes a 32-bit adder as four memory-mapped registers: two writable operands, a registered sum, and a status word. It sits behind the Zynq PS master port (or the AXI VIP master in simulation) and answers single-beat AXI4-Lite write and read transactions. It has one write and one read outstanding at most. Write address and write data are accepted in either order.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; bits [3:2] select the register and bits [1:0] are ignored.
- S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  reset, synchronous and active-high.
- S_AXI_AWADDR  in  4  write address. S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data. S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.

## Operation
- Register map:
  - 0x0 OPERAND_A, read/write.
  - 0x4 OPERAND_B, read/write.
  - 0x8 SUM, read-only, holds (A+B)[31:0].
  - 0xC STATUS, read-only:
    - [0] carry out of A+B.
    - [1] busy: sum update pending.
    - [15:2] zero.
    - [31:16] add counter, 16-bit, wraps 0xFFFF→0x0000.
- Write channel:
  - AW and W are latched independently into aw_pending and w_pending.
  - AWREADY = !aw_pending && !BVALID. WREADY = !w_pending && !BVALID.
  - The write commits in the cycle both address and data are held, or are being handshaken this cycle.
- Commit to 0x0 or 0x4:
  - Bytes are merged per WSTRB; a zero WSTRB changes nothing but still responds OKAY.
  - BRESP = OKAY (2'b00).
  - busy is set.
- Commit to 0x8 or 0xC: no register change and BRESP = SLVERR (2'b10).
- BVALID rises after the commit edge and holds with BRESP stable until BREADY. The pending flags clear at commit.
- Sum update:
  - Runs on the edge after busy is set.
  - SUM and carry are loaded from the current A and B.
  - The counter increments by 1 and busy clears.
  - A commit that lands while busy is still set re-sets busy, so exactly one update follows the final operand.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA is captured from register values as they stand before that edge's updates. RRESP = OKAY always.
  - RVALID holds with RDATA stable until RREADY.
- Reset forces, on the next edge:
  - Every output low: AWREADY, WREADY, ARREADY, BVALID, RVALID, and BRESP, RRESP, RDATA all zero.
  - A, B, SUM, STATUS, busy, aw_pending and w_pending all zero.
  - Any in-flight transaction is dropped and no response is issued.

## Timing
- AW and W handshaken together at edge N: BVALID is high from N+1 and SUM is valid from N+2.
- W at edge N and AW at edge N+3: the commit happens at N+3 and BVALID is high from N+4.
- BREADY already high when BVALID rises: BVALID is high for exactly one cycle. The next AW/W can be accepted in the cycle after BVALID drops.
- AR at edge N: RVALID is high from N+1. Back-to-back reads with RREADY held high give one read every 2 cycles.
- Write and read channels are fully independent; a write commit and an AR handshake in the same cycle are both served.
- First cycle after reset deasserts: all READY outputs go high (no pending state), and they are driven combinationally from the flags.

## Structure
- axi_adder_pkg holds:
  - Register offsets: ADDR_A = 2'd0, ADDR_B = 2'd1, ADDR_SUM = 2'd2, ADDR_STATUS = 2'd3.
  - Response constants: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Data and strobe width constants.
- Sub-module axi_adder_core:
  - Inputs: clock, reset, A, B, start.
  - Outputs: SUM, carry, busy, count.
  - The top level contains the AXI4-Lite handshake logic and the register file.

## Test plan
- Write A=0x00000001 and B=0x00000002 with AW and W in the same cycle, then read 0x8 → 0x00000003 OKAY. Read 0xC → 0x00020000.
- Write A=0xFFFFFFFF, then B=0x00000001 with W issued 3 cycles before AW → SUM=0x00000000 and STATUS[0]=1. BVALID appears the cycle after AW.
- Write 0xAABBCCDD to A with WSTRB=4'b0101 over A=0x11223344 → A reads back 0x11BB33DD.
- Write to 0x8 → BRESP=SLVERR and SUM unchanged. Read of any address → RRESP=OKAY.
- Hold BREADY and RREADY low for 5 cycles → BVALID, BRESP, RVALID and RDATA stay stable, and AWREADY, WREADY and ARREADY stay low.
- Assert reset mid-write with AW accepted but W not yet → no BVALID is issued. After reset, A reads 0x00000000 and STATUS reads 0x00000000.
